// File: rtl/max_scan_ctrl_pkg.sv
// max_scan_ctrl shared types.
// State enum built on the shared encodings.
package max_scan_ctrl_pkg;
`include "max_scan_defs.vh"

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/max_scan_ctrl_if.sv
// Sample stream into max_scan_ctrl.
// Source drives valid/data, scanner drives ready.
interface max_scan_ctrl_if #(
  parameter int WIDTH = 4
) ();
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/max_scan_ctrl_max2_cmp.sv
// Shared two-input unsigned comparator.
// Purely combinational; reused every cycle.
module max2_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic [WIDTH-1:0] max
);
  assign gt  = a > b;
  assign max = gt ? a : b;
endmodule

// File: rtl/max_scan_defs.vh
// max_scan_ctrl state encodings.
// Codes above ST_DONE are unused and recover to IDLE.
`ifndef MAX_SCAN_DEFS_VH
`define MAX_SCAN_DEFS_VH
localparam logic [1:0] ST_IDLE = 2'd0;
localparam logic [1:0] ST_RUN  = 2'd1;
localparam logic [1:0] ST_DONE = 2'd2;
`endif

// File: rtl/max_scan_ctrl.sv
// Sequential max-finder over a LEN-sample burst.
// Reports the max and its first index.
module max_scan_ctrl
  import max_scan_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LEN   = 8,
  localparam int IDXW = $clog2(LEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  max_scan_ctrl_if.slave  s,
  output logic            busy,
  output logic            done,
  output logic [WIDTH-1:0] max_out,
  output logic [IDXW-1:0] max_idx
);

  localparam logic [IDXW:0] LAST = (IDXW+1)'(LEN - 1);

  state_t           state_q;
  state_t           state_d;
  logic [IDXW:0]    cnt_q;
  logic [WIDTH-1:0] cur_max_q;
  logic [IDXW-1:0]  cur_idx_q;

  logic             gt;
  logic [WIDTH-1:0] mx;
  logic             hs;
  logic             accept;
  logic             first;
  logic             take;
  logic             last;
  logic             start_run;
  logic             finish;
  logic [WIDTH-1:0] nxt_max;
  logic [WIDTH-1:0] fin_max;
  logic [IDXW-1:0]  fin_idx;

  max2_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a   (s.in_data),
    .b   (cur_max_q),
    .gt  (gt),
    .max (mx)
  );

  assign s.in_ready = (state_q == S_RUN);
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);

  assign hs        = s.in_valid && s.in_ready;
  assign accept    = hs && !abort;
  assign first     = (cnt_q == '0);
  assign take      = first || gt;
  assign last      = (cnt_q == LAST);
  assign start_run = (state_q == S_IDLE) && start;
  assign finish    = accept && last;

  // first sample seeds the running max regardless of cur_max
  assign nxt_max = first ? s.in_data : mx;
  assign fin_max = take ? nxt_max : cur_max_q;
  assign fin_idx = take ? cnt_q[IDXW-1:0] : cur_idx_q;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next-state: abort outranks the final handshake
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (abort)       state_d = S_IDLE;
        else if (finish) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // counter, running max and held result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      cur_max_q <= '0;
      cur_idx_q <= '0;
      max_out   <= '0;
      max_idx   <= '0;
    end else begin
      if (start_run) begin
        cnt_q     <= '0;
        cur_max_q <= '0;
        cur_idx_q <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + 1'b1;
        if (take) begin
          cur_max_q <= nxt_max;
          cur_idx_q <= cnt_q[IDXW-1:0];
        end
      end
      if (finish) begin
        max_out <= fin_max;
        max_idx <= fin_idx;
      end
    end
  end

endmodule
